// File: rtl/text_video_if.sv
// Memory-side bus of the text video controller: text RAM and font ROM ports.
// The controller is the master (drives addresses); the memories answer with data.
interface text_video_if #(
    parameter int FONT_AW = 12
);
    logic [16:0]        char_address;
    logic [FONT_AW-1:0] font_address;
    logic [7:0]         char_data;
    logic [7:0]         font_data;

    modport master (output char_address, output font_address,
                    input  char_data,    input  font_data);
    modport slave  (input  char_address, input  font_address,
                    output char_data,    output font_data);
endinterface

// File: rtl/text_video_ctrl.sv
// VGA text-mode controller: 8-phase code/attr/glyph fetch, cursor, blink timer,
// registered 12-bit RGB with HS/VS and a one-cycle start-of-vblank interrupt.
module text_video_ctrl #(
    parameter int          H_VIS        = 640,
    parameter int          H_FRONT      = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BACK       = 48,
    parameter int          V_VIS        = 400,
    parameter int          V_FRONT      = 12,
    parameter int          V_SYNC       = 2,
    parameter int          V_BACK       = 35,
    parameter bit          HS_POL       = 1'b0,
    parameter bit          VS_POL       = 1'b1,
    parameter int          CHAR_H       = 16,
    parameter logic [16:0] VRAM_BASE    = 17'h1E000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic         clock,
    input  logic         reset_n,
    text_video_if.master mem,
    input  logic [10:0]  cursor,
    input  logic         cursor_en,
    input  logic [3:0]   cur_start,
    input  logic [3:0]   cur_end,
    input  logic         blink_mode,
    output logic [3:0]   r,
    output logic [3:0]   g,
    output logic [3:0]   b,
    output logic         hs,
    output logic         vs,
    output logic         irq
);
    localparam int          LW       = $clog2(CHAR_H);
    localparam int          COLS     = H_VIS / 8;
    localparam int          ROWS     = V_VIS / CHAR_H;
    localparam int          BW       = $clog2(BLINK_FRAMES + 1);
    localparam logic [10:0] CELLS    = 11'(COLS * ROWS);
    localparam logic [10:0] COLS11   = 11'(COLS);
    localparam logic [10:0] H_LAST   = 11'(H_BACK + H_VIS + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] V_LAST   = 11'(V_BACK + V_VIS + V_FRONT + V_SYNC - 1);
    localparam logic [10:0] HA_BEG   = 11'(H_BACK);
    localparam logic [10:0] HA_END   = 11'(H_BACK + H_VIS);
    localparam logic [10:0] HS_BEG   = 11'(H_BACK + H_VIS + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_BACK + H_VIS + H_FRONT + H_SYNC);
    localparam logic [10:0] VA_BEG   = 11'(V_BACK);
    localparam logic [10:0] VA_END   = 11'(V_BACK + V_VIS);
    localparam logic [10:0] VS_BEG   = 11'(V_BACK + V_VIS + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_BACK + V_VIS + V_FRONT + V_SYNC);

    logic [10:0]   x, y, x_nxt, y_nxt;
    logic [10:0]   px, row, cell_id;
    logic [2:0]    phase;
    logic [3:0]    line4;
    logic          active;
    logic [7:0]    glyph_n, attr_n, shifter, attr;
    logic          bmode, cur_hit, blink;
    logic [BW-1:0] frame_cnt;
    logic [11:0]   rgb;
    logic [3:0]    fg, bg, cidx;
    logic          show_fg;

    function automatic logic [11:0] palette(input logic [3:0] idx);
        case (idx)
            4'h0: palette = 12'h111;  4'h1: palette = 12'h008;
            4'h2: palette = 12'h080;  4'h3: palette = 12'h088;
            4'h4: palette = 12'h800;  4'h5: palette = 12'h808;
            4'h6: palette = 12'h880;  4'h7: palette = 12'hCCC;
            4'h8: palette = 12'h888;  4'h9: palette = 12'h00F;
            4'hA: palette = 12'h0F0;  4'hB: palette = 12'h0FF;
            4'hC: palette = 12'hF00;  4'hD: palette = 12'hF0F;
            4'hE: palette = 12'hFF0;  default: palette = 12'hFFF;
        endcase
    endfunction

    always_comb begin
        x_nxt = x + 11'd1;
        y_nxt = y;
        if (x == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y == V_LAST) ? '0 : y + 11'd1;
        end
    end

    // Fetch runs one cell (8 px) ahead of the pixel being displayed.
    assign px      = x - HA_BEG + 11'd8;
    assign row     = y - VA_BEG;
    assign phase   = px[2:0];
    assign line4   = 4'(row[LW-1:0]);
    assign cell_id = 11'(px[10:3]) + 11'(row[10:LW]) * COLS11;
    assign active  = (x >= HA_BEG) && (x < HA_END) && (y >= VA_BEG) && (y < VA_END);

    always_comb begin
        fg      = attr[3:0];
        bg      = bmode ? {1'b0, attr[6:4]} : attr[7:4];
        show_fg = cur_hit || (shifter[7] && !(bmode && attr[7] && blink));
        cidx    = show_fg ? fg : bg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x                <= '0;
            y                <= '0;
            hs               <= ~HS_POL;
            vs               <= ~VS_POL;
            irq              <= 1'b0;
            rgb              <= '0;
            mem.char_address <= '0;
            mem.font_address <= '0;
            glyph_n          <= '0;
            attr_n           <= '0;
            shifter          <= '0;
            attr             <= '0;
            bmode            <= 1'b0;
            cur_hit          <= 1'b0;
            blink            <= 1'b0;
            frame_cnt        <= '0;
        end else begin
            x   <= x_nxt;
            y   <= y_nxt;
            // Sync/irq decoded from the next count so they stay registered yet align with x.
            hs  <= (x_nxt >= HS_BEG && x_nxt < HS_END) ? HS_POL : ~HS_POL;
            vs  <= (y_nxt >= VS_BEG && y_nxt < VS_END) ? VS_POL : ~VS_POL;
            irq <= (x_nxt == '0) && (y_nxt == VA_END);

            if (irq) begin
                if (frame_cnt == BW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            case (phase)
                3'd0: mem.char_address <= VRAM_BASE + {5'b0, cell_id, 1'b0};
                3'd2: begin
                    mem.font_address <= {mem.char_data, row[LW-1:0]};
                    mem.char_address <= mem.char_address + 17'd1;
                end
                3'd4: begin
                    glyph_n <= mem.font_data;
                    attr_n  <= mem.char_data;
                end
                default: ;
            endcase

            if (phase == 3'd7) begin
                shifter <= glyph_n;
                attr    <= attr_n;
                bmode   <= blink_mode;
                cur_hit <= cursor_en && blink && (cursor == cell_id) && (cursor < CELLS) &&
                           (cur_start <= line4) && (line4 <= cur_end);
            end else begin
                shifter <= {shifter[6:0], 1'b0};
            end

            rgb <= active ? palette(cidx) : '0;
        end
    end

    assign r = rgb[11:8];
    assign g = rgb[7:4];
    assign b = rgb[3:0];
endmodule
